// File: rtl/mux_2_1.sv
`default_nettype none
//============================================================================
// Module   : mux_2_1
// Purpose  : Gate-level 2:1 multiplexer, WIDTH bits wide. OUT follows A when
//            SEL=0 and B when SEL=1. With REG_OUT=1 the selected value is
//            captured on the rising edge of CLK (one cycle of latency), and a
//            synchronous active-high RST loads RESET_VAL.
// Ports    : CLK  in  1      clock (used only when REG_OUT=1)
//            RST  in  1      synchronous active-high reset (REG_OUT=1 only)
//            SEL  in  1      select: 0 -> A, 1 -> B
//            A    in  WIDTH  data input 0
//            B    in  WIDTH  data input 1
//            OUT  out WIDTH  selected data
// Revision : 1.0 - initial release
//============================================================================
module mux_2_1 #(
  parameter int               WIDTH     = 1,
  parameter int               REG_OUT   = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SEL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] OUT
);

  // Select datapath, built from gate primitives so that X on SEL propagates
  // to the output while X on the unselected input is masked by its AND gate.
  wire             w_sel_n;
  wire [WIDTH-1:0] w_a_term;
  wire [WIDTH-1:0] w_b_term;
  wire [WIDTH-1:0] w_mux;

  // Single inverter on SEL, shared by every bit slice.
  not u_sel_inv (w_sel_n, SEL);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      and u_and_a (w_a_term[gi], A[gi], w_sel_n);
      and u_and_b (w_b_term[gi], B[gi], SEL);
      or  u_or    (w_mux[gi], w_a_term[gi], w_b_term[gi]);
    end
  endgenerate

  // Output stage: exactly one of the two paths is elaborated.
  generate
    if (REG_OUT != 0) begin : g_reg
      logic [WIDTH-1:0] r_out;

      always_ff @(posedge CLK) begin
        if (RST) begin
          r_out <= RESET_VAL;
        end else begin
          r_out <= w_mux;
        end
      end

      assign OUT = r_out;
    end else begin : g_comb
      // Clock and reset have no function in the combinational mode.
      wire w_unused_clk_rst;
      assign w_unused_clk_rst = CLK ^ RST;

      assign OUT = w_mux;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mux_2_1.sv
`default_nettype none
//============================================================================
// Module   : tb_mux_2_1
// Purpose  : Self-checking bench for mux_2_1. Three instances cover the
//            combinational 1-bit and 8-bit modes and the registered 4-bit
//            mode. Expected values are queued when stimulus is driven and
//            popped when the output is sampled.
// Revision : 1.0 - initial release
//============================================================================
module tb_mux_2_1;

  // Free-running clock for the registered instance.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 1-bit combinational instance; its CLK/RST are toggled by hand.
  logic c1_clk = 1'b0;
  logic c1_rst = 1'b0;
  logic c1_sel, c1_a, c1_b;
  logic c1_out;

  // 8-bit combinational instance.
  logic       c8_sel;
  logic [7:0] c8_a, c8_b, c8_out;

  // 4-bit registered instance.
  logic       r4_rst;
  logic       r4_sel;
  logic [3:0] r4_a, r4_b, r4_out;

  mux_2_1 #(.WIDTH(1), .REG_OUT(0)) u_c1 (
    .CLK(c1_clk), .RST(c1_rst), .SEL(c1_sel), .A(c1_a), .B(c1_b), .OUT(c1_out)
  );

  mux_2_1 #(.WIDTH(8), .REG_OUT(0)) u_c8 (
    .CLK(clk), .RST(r4_rst), .SEL(c8_sel), .A(c8_a), .B(c8_b), .OUT(c8_out)
  );

  mux_2_1 #(.WIDTH(4), .REG_OUT(1), .RESET_VAL(4'h9)) u_r4 (
    .CLK(clk), .RST(r4_rst), .SEL(r4_sel), .A(r4_a), .B(r4_b), .OUT(r4_out)
  );

  // Scoreboard
  logic [7:0] sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic push(input logic [7:0] exp);
    sb_q.push_back(exp);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  logic probe;
  logic four_state;

  initial begin
    c1_sel = 1'b0; c1_a = 1'b0; c1_b = 1'b0;
    c8_sel = 1'b0; c8_a = 8'h00; c8_b = 8'h00;
    r4_rst = 1'b1; r4_sel = 1'b0; r4_a = 4'h0; r4_b = 4'h0;

    // ---------------- combinational, 1 bit, directed steps
    c1_sel = 1'b0; c1_a = 1'b0; c1_b = 1'b1; push(8'h00);
    #5 check("c1_step_a0", {7'b0, c1_out});
    c1_a = 1'b1; push(8'h01);
    #5 check("c1_step_a1", {7'b0, c1_out});
    c1_sel = 1'b1; push(8'h01);
    #5 check("c1_step_sel1", {7'b0, c1_out});
    c1_b = 1'b0; push(8'h00);
    #5 check("c1_step_b0", {7'b0, c1_out});

    // ---------------- combinational, 1 bit, exhaustive with CLK/RST toggling
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      c1_sel = v[2]; c1_a = v[1]; c1_b = v[0];
      c1_clk = ~c1_clk;
      c1_rst = v[0] ^ v[2];
      push({7'b0, (v[2] ? v[0] : v[1])});
      #5 check($sformatf("c1_sweep_%0d", i), {7'b0, c1_out});
    end

    // ---------------- combinational, 8 bits
    c8_a = 8'hA5; c8_b = 8'h3C; c8_sel = 1'b0; push(8'hA5);
    #5 check("c8_sel0", c8_out);
    c8_sel = 1'b1; push(8'h3C);
    #5 check("c8_sel1", c8_out);
    c8_a = 8'hxx; push(8'h3C);
    #5 check("c8_unsel_x", c8_out);

    // ---------------- X on select, 1 bit
    probe = 1'bx;
    four_state = $isunknown(probe);
    c1_sel = 1'bx; c1_a = 1'b0; c1_b = 1'b1;
    if (four_state) push(8'b0000000x);
    else            push({7'b0, (c1_sel ? c1_b : c1_a)});
    #5 check("c1_sel_x", {7'b0, c1_out});

    // ---------------- registered, 4 bits, reset
    @(negedge clk);
    r4_rst = 1'b1; r4_a = 4'h1; r4_b = 4'h2; r4_sel = 1'b0;
    push(8'h09);
    @(posedge clk); #1 check("r4_rst_edge1", {4'b0, r4_out});
    push(8'h09);
    @(posedge clk); #1 check("r4_rst_edge2", {4'b0, r4_out});

    @(negedge clk);
    r4_rst = 1'b0; r4_sel = 1'b1; push(8'h02);
    @(posedge clk); #1 check("r4_rst_release", {4'b0, r4_out});

    // ---------------- registered latency
    @(negedge clk);
    r4_sel = 1'b0; push(8'h01);
    @(posedge clk); #1 check("r4_lat_sel0", {4'b0, r4_out});
    @(negedge clk);
    r4_sel = 1'b1; push(8'h01); push(8'h02);
    #1 check("r4_lat_hold", {4'b0, r4_out});
    @(posedge clk); #1 check("r4_lat_update", {4'b0, r4_out});

    @(negedge clk);
    r4_a = 4'h7; r4_sel = 1'b0; push(8'h07);
    @(posedge clk); #1 check("r4_data_a7", {4'b0, r4_out});

    // Mid-stream reset discards the pending value.
    @(negedge clk);
    r4_rst = 1'b1; r4_a = 4'hC; push(8'h09);
    @(posedge clk); #1 check("r4_mid_rst", {4'b0, r4_out});

    @(negedge clk);
    r4_rst = 1'b0; r4_sel = 1'b1; r4_b = 4'h5; push(8'h05);
    @(posedge clk); #1 check("r4_after_rst", {4'b0, r4_out});

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL sb_drain: observed=%0d leftover entries expected=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed=no finish expected=finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
